// File: rtl/logging_bram_arb.sv
// Two-master Wishbone arbiter in front of a single BRAM port: m0 is the write-only logger, m1 the read window.
// Optional watchdog abort of stalled strobes is built when LOGGING_ARB_WATCHDOG_EN is defined.
module logging_bram_arb #(
  parameter int ADR_W   = 12,
  parameter int TIMEOUT = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [15:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  output logic [15:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [15:0]      s_dat_o,
  input  logic [15:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // 0 = m0 granted last, 1 = m1
  logic   abort;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (abort) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? GNT1 : IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (abort) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? GNT0 : IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus steering; an aborting cycle drops the slave strobe and swallows any ack.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~abort;
        s_stb_o  = m0_stb_i & ~abort;
        s_we_o   = m0_we_i & ~abort;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & ~abort;
        m0_err_o = abort;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~abort;
        s_stb_o  = m1_stb_i & ~abort;
        s_adr_o  = m1_adr_i;
        m1_ack_o = s_ack_i & ~abort;
        m1_err_o = abort;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o = state_q;

`ifdef LOGGING_ARB_WATCHDOG_EN
  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  assign abort = (state_q != IDLE) && (wd_cnt_q == CNT_LIMIT);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE || state_d != state_q || s_ack_i) wd_cnt_d = '0;
    else if (s_stb_o)                                       wd_cnt_d = wd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) wd_cnt_q <= '0;
    else             wd_cnt_q <= wd_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_logging_bram_arb.sv
// Bench for logging_bram_arb: registered-ack BRAM model, per-master scoreboards checked on each ack.
module tb_logging_bram_arb;

  logic        clk = 1'b0;
  logic        wb_rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [11:0] m0_adr;
  logic [15:0] m0_dat;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb;
  logic [11:0] m1_adr;
  logic [15:0] m1_dat;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [11:0] s_adr;
  logic [15:0] s_dat_o, s_dat_i;
  logic        s_ack;
  logic [1:0]  gnt;

  always #5 clk = ~clk;

  logging_bram_arb #(.ADR_W(12), .TIMEOUT(16)) dut (
    .wb_clk_i  (clk),     .wb_rst_n_i(wb_rst_n),
    .m0_cyc_i  (m0_cyc),  .m0_stb_i  (m0_stb),  .m0_we_i (m0_we),
    .m0_adr_i  (m0_adr),  .m0_dat_i  (m0_dat),
    .m0_ack_o  (m0_ack),  .m0_err_o  (m0_err),
    .m1_cyc_i  (m1_cyc),  .m1_stb_i  (m1_stb),  .m1_adr_i(m1_adr),
    .m1_dat_o  (m1_dat),  .m1_ack_o  (m1_ack),  .m1_err_o(m1_err),
    .s_cyc_o   (s_cyc),   .s_stb_o   (s_stb),   .s_we_o  (s_we),
    .s_adr_o   (s_adr),   .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i), .s_ack_i   (s_ack),
    .gnt_o     (gnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return (i == 16) ? 16'h1234 : 16'(i ^ 16'hA5A5);
  endfunction

  // BRAM model: one-cycle registered ack, stall switch for watchdog tests
  logic [15:0] mem [4096];
  logic        mem_init = 1'b0;
  logic        bram_stall;
  logic        bram_ack;
  logic [15:0] bram_rd;
  assign s_ack   = bram_ack;
  assign s_dat_i = bram_rd;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end
    if (!wb_rst_n) begin
      bram_ack <= 1'b0;
      bram_rd  <= 16'h0;
    end else begin
      bram_ack <= 1'b0;
      if (s_cyc && s_stb && !bram_ack && !bram_stall) begin
        bram_ack <= 1'b1;
        if (s_we) mem[s_adr] <= s_dat_o;
        bram_rd <= mem[s_adr];
      end
    end
  end

  typedef struct packed {
    logic [11:0] adr;
    logic [15:0] dat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          ack_order[$];
  logic [15:0] ref_mem [4096];
  exp_t        mon_e;

  // Scoreboard monitor: pop the expected transfer on every ack
  always @(negedge clk) begin
    if (wb_rst_n) begin
      if (m0_ack) begin
        ack_order.push_back(0);
        if (q0.size() == 0) check_eq("m0_spurious_ack", 32'(m0_ack), 32'h0);
        else begin
          mon_e = q0.pop_front();
          check_eq("m0_s_adr", 32'(s_adr), 32'(mon_e.adr));
          check_eq("m0_s_dat", 32'(s_dat_o), 32'(mon_e.dat));
          check_eq("m0_s_we", 32'(s_we), 32'h1);
          check_eq("m0_gnt", 32'(gnt), 32'h1);
          check_eq("m0_other_ack", 32'(m1_ack), 32'h0);
        end
      end
      if (m1_ack) begin
        ack_order.push_back(1);
        if (q1.size() == 0) check_eq("m1_spurious_ack", 32'(m1_ack), 32'h0);
        else begin
          mon_e = q1.pop_front();
          check_eq("m1_rd_dat", 32'(m1_dat), 32'(mon_e.dat));
          check_eq("m1_s_adr", 32'(s_adr), 32'(mon_e.adr));
          check_eq("m1_s_we", 32'(s_we), 32'h0);
          check_eq("m1_gnt", 32'(gnt), 32'h2);
          check_eq("m1_other_ack", 32'(m0_ack), 32'h0);
        end
      end
    end
  end

  task automatic m0_write(input logic [11:0] adr, input logic [15:0] dat);
    exp_t e;
    int   n;
    e.adr = adr;
    e.dat = dat;
    q0.push_back(e);
    ref_mem[adr] = dat;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = adr; m0_dat = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_ack && n < 64);
    if (!m0_ack) check_eq("m0_ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
  endtask

  task automatic m1_read(input logic [11:0] adr);
    exp_t e;
    int   n;
    e.adr = adr;
    e.dat = ref_mem[adr];
    q1.push_back(e);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = adr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m1_ack && n < 64);
    if (!m1_ack) check_eq("m1_ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  int   n_stb;
  int   wait_n;
  logic got_err;
  logic err_seen;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    wb_rst_n = 1'b0; bram_stall = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_adr = '0;

    // Reset state, with m0 cyc already high while in reset
    repeat (3) @(posedge clk);
    m0_cyc = 1'b1;
    @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_s_stb", 32'(s_stb), 32'h0);
    check_eq("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    wb_rst_n = 1'b1;
    #1 check_eq("rel_no_early_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    check_eq("rel_first_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    m0_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("idle_gnt", 32'(gnt), 32'h0);
    check_eq("idle_bus", 32'({s_cyc, s_stb, s_we}), 32'h0);

    // Single logger write with start-up latency
    do_reset();
    fork
      m0_write(12'h005, 16'hBEEF);
      begin
        @(negedge clk);
        check_eq("lat_idle_stb", 32'(s_stb), 32'h0);
        @(negedge clk);
        check_eq("lat_stb", 32'(s_stb), 32'h1);
        check_eq("lat_gnt", 32'(gnt), 32'h1);
      end
    join

    // Simultaneous requests: m0 first, gapless handoff to m1
    do_reset();
    ack_order.delete();
    fork
      m0_write(12'h020, 16'h5555);
      m1_read(12'h010);
      begin
        wait_n = 0;
        while (!m0_ack && wait_n < 64) begin
          @(negedge clk);
          wait_n++;
        end
        @(negedge clk);
        check_eq("ho_hold_gnt0", 32'(gnt), 32'h1);
        @(negedge clk);
        check_eq("ho_gnt1_no_gap", 32'(gnt), 32'h2);
      end
    join
    check_eq("ho_ack_count", 32'(ack_order.size()), 32'h2);
    if (ack_order.size() == 2) check_eq("ho_first_m0", 32'(ack_order[0]), 32'h0);

    // Continuous contention alternates grants
    do_reset();
    ack_order.delete();
    fork
      for (int i = 0; i < 3; i++) begin
        m0_write(12'h030 + 12'(i), 16'hC000 + 16'(i));
        @(posedge clk); #1;
      end
      begin
        m1_read(12'h005);
        @(posedge clk); #1;
        m1_read(12'h020);
        @(posedge clk); #1;
        m1_read(12'h010);
      end
    join
    check_eq("alt_ack_count", 32'(ack_order.size()), 32'h6);
    for (int i = 0; i < ack_order.size(); i++)
      check_eq($sformatf("alt_order_%0d", i), 32'(ack_order[i]), 32'(i % 2));

    // Stalled BRAM on the read window
    do_reset();
    bram_stall = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h040;
`ifdef LOGGING_ARB_WATCHDOG_EN
    n_stb = 0;
    got_err = 1'b0;
    for (int c = 0; c < 64 && !got_err; c++) begin
      @(negedge clk);
      if (m1_err) begin
        got_err = 1'b1;
        check_eq("wd_abort_stb_low", 32'(s_stb), 32'h0);
        check_eq("wd_m0_err", 32'(m0_err), 32'h0);
      end else if (s_stb) n_stb++;
    end
    check_eq("wd_err_seen", 32'(got_err), 32'h1);
    check_eq("wd_stb_cycles", 32'(n_stb), 32'd16);
    @(negedge clk);
    check_eq("wd_gnt_idle", 32'(gnt), 32'h0);
    check_eq("wd_err_single", 32'(m1_err), 32'h0);
`else
    err_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (m0_err || m1_err) err_seen = 1'b1;
    end
    check_eq("nowd_stb_held", 32'(s_stb), 32'h1);
    check_eq("nowd_gnt_held", 32'(gnt), 32'h2);
    check_eq("nowd_no_err", 32'(err_seen), 32'h0);
`endif
    @(posedge clk); #1;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    bram_stall = 1'b0;

    // Asynchronous reset in the middle of a window transfer
    do_reset();
    bram_stall = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h010;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_gnt1", 32'(gnt), 32'h2);
    check_eq("mid_stb", 32'(s_stb), 32'h1);
    #1 wb_rst_n = 1'b0;
    #1;
    check_eq("arst_bus", 32'({s_cyc, s_stb}), 32'h0);
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    check_eq("arst_m1_dat", 32'(m1_dat), 32'h0);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    bram_stall = 1'b0;
    @(negedge clk);
    wb_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    check_eq("q0_drained", 32'(q0.size()), 32'h0);
    check_eq("q1_drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logging_bram_arb.md
LOGGING_BRAM_ARB -- requirements
Module: logging_bram_arb

Interface
REQ-001 Parameter ADR_W, default 12, BRAM word-address width.
REQ-002 Parameter TIMEOUT, default 16, cycles of unacked strobe before watchdog abort.
REQ-003 wb_clk_i  in  1  single clock; all state on rising edge.
REQ-004 wb_rst_n_i  in  1  reset; asynchronous and active-low.
REQ-005 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  logger (write master) cycle, strobe, write enable.
REQ-006 m0_adr_i  in  ADR_W  logger address.
REQ-007 m0_dat_i  in  16  logger write data.
REQ-008 m0_ack_o, m0_err_o  out  1 each  logger ack, watchdog error.
REQ-009 m1_cyc_i, m1_stb_i  in  1 each  sbus read-window master cycle, strobe (read only).
REQ-010 m1_adr_i  in  ADR_W  read-window address.
REQ-011 m1_dat_o  out  16  read data to window.
REQ-012 m1_ack_o, m1_err_o  out  1 each  window ack, watchdog error.
REQ-013 s_cyc_o, s_stb_o, s_we_o  out  1 each  BRAM port cycle, strobe, write enable.
REQ-014 s_adr_o  out  ADR_W  BRAM address; s_dat_o  out  16  BRAM write data.
REQ-015 s_dat_i  in  16  BRAM read data; s_ack_i  in  1  BRAM ack.
REQ-016 gnt_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1.
- IDLE: neither cyc -> stay; one cyc -> that grant on next edge; both -> grant master not in last-granted register.
REQ-018 In GNTn, when mn_cyc_i is low at an edge, the FSM SHALL go to GNT(other) if the other cyc is high, else IDLE; last-granted SHALL update to n.
REQ-019 The grant SHALL be held for the whole time mn_cyc_i is high; no preemption.
REQ-020 In GNTn, s_cyc_o/s_stb_o/s_adr_o SHALL follow mn combinationally; s_we_o = m0_we_i in GNT0, 0 in GNT1; s_dat_o = m0_dat_i in GNT0, 0 otherwise.
REQ-021 In IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0.
REQ-022 s_ack_i SHALL route combinationally only to the granted master's ack; the non-granted ack SHALL be 0.
REQ-023 m1_dat_o SHALL equal s_dat_i in GNT1 and 16'h0000 otherwise.
REQ-024 Latency: first cyc seen in IDLE -> s_stb_o high the following cycle; handoff GNT0->GNT1 SHALL insert no IDLE cycle.
REQ-025 A master's request dropped while not granted SHALL be ignored with no residual grant.
REQ-026 gnt_o SHALL be registered state, not decoded from inputs.

Reset
REQ-027 Assertion of wb_rst_n_i SHALL immediately force IDLE, last-granted = m1 (so m0 wins first tie), watchdog count 0, all outputs 0 including mid-transfer.
REQ-028 After deassertion, the first grant SHALL occur no earlier than the first rising edge with wb_rst_n_i high.

Configuration
REQ-029 Macro LOGGING_ARB_WATCHDOG_EN defined: a counter SHALL count cycles with s_stb_o=1 and s_ack_i=0, clear on ack or state change; on reaching TIMEOUT, it SHALL pulse the granted master's err_o for one cycle, force s_cyc_o/s_stb_o to 0 that cycle, go to IDLE, and set last-granted to the aborted master.
REQ-030 Macro undefined: no counter SHALL be built, m0_err_o and m1_err_o SHALL be tied 0, and a grant SHALL wait indefinitely for ack.

Verification
REQ-031 Reset then m0 cyc/stb/we, adr 0x005, dat 0xBEEF; BRAM acks in 1 cycle -> s_we_o=1, s_adr_o=0x005, m0_ack_o one cycle, m1_ack_o=0, gnt_o=01.
REQ-032 m0 and m1 cyc rise same cycle after reset -> GNT0 first; m0 drops cyc -> gnt_o=10 next cycle, no idle gap; m1_dat_o = BRAM word 0x1234 at addr 0x010.
REQ-033 Both request continuously, cycles of 1 transfer each -> grants alternate 01,10,01,10.
REQ-034 LOGGING_ARB_WATCHDOG_EN, TIMEOUT=16, BRAM never acks m1 -> after 16 stb cycles m1_err_o pulses once, s_stb_o low, gnt_o=00; undefined -> stb held, err 0 after 100 cycles.
REQ-035 wb_rst_n_i asserted mid-GNT1 transfer -> s_cyc_o, s_stb_o, gnt_o, acks 0 immediately without clock edge.
